// File: rtl/dmem_access_unit_if.sv
// Valid/ready data-memory bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_wstrb;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: turns load/store requests into one bus
// transaction, steers byte lanes and extends load results, stalling meanwhile.
module dmem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                memory_busy,
    output logic [DATA_W-1:0]   load_data,
    output logic                access_done,
    output logic                misaligned_fault,
    dmem_access_unit_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic              bus_valid_r;
    logic              bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [3:0]        bus_wstrb_r;
    logic [2:0]        f3_r;
    logic [1:0]        ofs_r;
    logic              access_done_r;
    logic              fault_r;
    logic [DATA_W-1:0] load_data_r;

    logic              req_s;
    logic              is_byte_s;
    logic              is_half_s;
    logic              misaligned_s;
    logic [3:0]        strb_s;
    logic [DATA_W-1:0] bwdata_s;

    function automatic logic [3:0] lane_strb(input logic is_byte, input logic is_half,
                                             input logic [1:0] ofs);
        logic [3:0] s;
        if (is_byte) begin
            s = 4'b0001 << ofs;
        end else if (is_half) begin
            s = 4'b0011 << ofs;
        end else begin
            s = 4'b1111;
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] lane_wdata(input logic is_byte, input logic is_half,
                                                     input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] w;
        if (is_byte) begin
            w = {4{d[7:0]}};
        end else if (is_half) begin
            w = {2{d[15:0]}};
        end else begin
            w = d;
        end
        return w;
    endfunction

    // funct3 bit 2 selects zero extension; unlisted codes fall through to a word load.
    function automatic logic [DATA_W-1:0] extract_load(input logic [DATA_W-1:0] word,
                                                       input logic [2:0] f3,
                                                       input logic [1:0] ofs);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] r;
        sh = word >> {ofs, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Access size decode; 100/101 are byte/half only for loads, otherwise word.
    always_comb begin
        is_byte_s = 1'b0;
        is_half_s = 1'b0;
        case (funct3)
            3'b000:  is_byte_s = 1'b1;
            3'b001:  is_half_s = 1'b1;
            3'b100:  is_byte_s = mem_read;
            3'b101:  is_half_s = mem_read;
            default: begin
                is_byte_s = 1'b0;
                is_half_s = 1'b0;
            end
        endcase
    end

    // Alignment check and lane steering of the incoming request.
    always_comb begin
        req_s = mem_read | mem_write;
        if (is_byte_s) begin
            misaligned_s = 1'b0;
        end else if (is_half_s) begin
            misaligned_s = addr[0];
        end else begin
            misaligned_s = |addr[1:0];
        end
        if (mem_write) begin
            strb_s = lane_strb(is_byte_s, is_half_s, addr[1:0]);
        end else begin
            strb_s = 4'b0000;
        end
        bwdata_s = lane_wdata(is_byte_s, is_half_s, wdata);
    end

    // Transaction FSM with registered bus and completion outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            bus_valid_r   <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= {ADDR_W{1'b0}};
            bus_wdata_r   <= {DATA_W{1'b0}};
            bus_wstrb_r   <= 4'b0000;
            f3_r          <= 3'b000;
            ofs_r         <= 2'b00;
            access_done_r <= 1'b0;
            fault_r       <= 1'b0;
            load_data_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    access_done_r <= 1'b0;
                    fault_r       <= 1'b0;
                    if (req_s && misaligned_s) begin
                        state_r       <= ST_DONE;
                        access_done_r <= 1'b1;
                        fault_r       <= 1'b1;
                    end else if (req_s) begin
                        state_r     <= ST_REQ;
                        bus_valid_r <= 1'b1;
                        bus_we_r    <= mem_write;
                        bus_addr_r  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_wdata_r <= bwdata_s;
                        bus_wstrb_r <= strb_s;
                        f3_r        <= funct3;
                        ofs_r       <= addr[1:0];
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ready) begin
                        bus_valid_r <= 1'b0;
                        if (bus_we_r) begin
                            state_r       <= ST_DONE;
                            access_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_rvalid) begin
                        state_r       <= ST_DONE;
                        access_done_r <= 1'b1;
                        load_data_r   <= extract_load(bus.bus_rdata, f3_r, ofs_r);
                    end
                end
                ST_DONE: begin
                    state_r       <= ST_IDLE;
                    access_done_r <= 1'b0;
                    fault_r       <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    bus_valid_r   <= 1'b0;
                    access_done_r <= 1'b0;
                    fault_r       <= 1'b0;
                end
            endcase
        end
    end

    // The stall rises in the very cycle a request appears and drops only in DONE.
    assign memory_busy      = req_s & (state_r != ST_DONE);
    assign load_data        = load_data_r;
    assign access_done      = access_done_r;
    assign misaligned_fault = fault_r;
    assign bus.bus_valid    = bus_valid_r;
    assign bus.bus_we       = bus_we_r;
    assign bus.bus_addr     = bus_addr_r;
    assign bus.bus_wdata    = bus_wdata_r;
    assign bus.bus_wstrb    = bus_wstrb_r;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Table-driven scoreboard bench for dmem_access_unit with a responsive bus model
// and hand-written reset / idle-bus sequences.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memory_busy;
    logic [31:0] load_data;
    logic        access_done;
    logic        misaligned_fault;

    always #5 clk = ~clk;

    dmem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .funct3           (funct3),
        .addr             (addr),
        .wdata            (wdata),
        .memory_busy      (memory_busy),
        .load_data        (load_data),
        .access_done      (access_done),
        .misaligned_fault (misaligned_fault),
        .bus              (bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rv_dly;
        logic [3:0]  strb;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic [31:0] load;
        logic        fault;
        int          lat;
    } vec_t;

    vec_t vecs[16];
    vec_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdat, input int rdy, input int rv,
                                input logic [3:0] strb, input logic [31:0] bwd,
                                input logic [31:0] baddr, input logic [31:0] ld,
                                input logic fault, input int lat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.rdy_dly = rdy; v.rv_dly = rv; v.strb = strb; v.bwdata = bwd; v.baddr = baddr;
        v.load = ld; v.fault = fault; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a negedge in an IDLE cycle; returns after the next one.
    task automatic run(input vec_t v, input string tag);
        int   c;
        int   vcnt;
        int   rcnt;
        int   busy_cnt;
        int   mism;
        logic hs;
        logic done;
        vec_t e;
        mem_read  = v.rd;
        mem_write = v.wr;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wdata;
        sbq.push_back(v);
        c = 0; vcnt = 0; rcnt = 0; busy_cnt = 0; mism = 0; hs = 1'b0; done = 1'b0;
        while (!done && c < 40) begin
            #1;
            if (access_done) begin
                done = 1'b1;
                e = sbq.pop_front();
                chk({tag, " latency"}, c, e.lat);
                chk({tag, " fault"}, {31'd0, misaligned_fault}, {31'd0, e.fault});
                chk({tag, " busy_at_done"}, {31'd0, memory_busy}, 32'd0);
                chk({tag, " busy_cycles"}, busy_cnt, e.lat);
                chk({tag, " valid_cycles"}, vcnt, e.fault ? 0 : e.rdy_dly + 1);
                chk({tag, " bus_stable"}, mism, 32'd0);
                if (e.rd && !e.fault) chk({tag, " load_data"}, load_data, e.load);
            end else begin
                if (memory_busy) busy_cnt++;
                if (bus.bus_valid) begin
                    vcnt++;
                    if (vcnt == 1) begin
                        chk({tag, " bus_addr"}, bus.bus_addr, v.baddr);
                        chk({tag, " bus_wstrb"}, {28'd0, bus.bus_wstrb}, {28'd0, v.strb});
                        if (v.wr) chk({tag, " bus_wdata"}, bus.bus_wdata, v.bwdata);
                    end
                    if (bus.bus_addr !== v.baddr || bus.bus_wstrb !== v.strb ||
                        bus.bus_we !== v.wr || (v.wr && bus.bus_wdata !== v.bwdata)) mism++;
                    bus.bus_ready = (vcnt > v.rdy_dly);
                    if (vcnt > v.rdy_dly) hs = 1'b1;
                end else if (hs) begin
                    bus.bus_rdata  = v.rdata;
                    bus.bus_rvalid = (rcnt >= v.rv_dly);
                    rcnt++;
                end
            end
            @(negedge clk);
            bus.bus_ready  = 1'b0;
            bus.bus_rvalid = 1'b0;
            c++;
        end
        if (!done) begin
            chk({tag, " timeout"}, c, 32'd0);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        chk({tag, " done_pulse_width"}, {31'd0, access_done}, 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h100, 32'h0, 1'b0, 2);
        vecs[1]  = mk(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 4'h8, 32'hA5A5A5A5, 32'h100, 32'h0, 1'b0, 2);
        vecs[2]  = mk(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 2, 0, 4'hC, 32'hBEEFBEEF, 32'h100, 32'h0, 1'b0, 4);
        vecs[3]  = mk(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 32'h12F03456, 0, 3, 4'h0, 32'h0, 32'h200, 32'hFFFFFFF0, 1'b0, 6);
        vecs[4]  = mk(1'b1, 1'b0, 3'b100, 32'h202, 32'h0, 32'h12F03456, 0, 3, 4'h0, 32'h0, 32'h200, 32'h000000F0, 1'b0, 6);
        vecs[5]  = mk(1'b1, 1'b0, 3'b001, 32'h201, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        vecs[6]  = mk(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 4, 0, 4'h0, 32'h0, 32'h204, 32'hCAFEF00D, 1'b0, 7);
        vecs[7]  = mk(1'b1, 1'b0, 3'b001, 32'h206, 32'h0, 32'h80017FFF, 0, 0, 4'h0, 32'h0, 32'h204, 32'hFFFF8001, 1'b0, 3);
        vecs[8]  = mk(1'b1, 1'b0, 3'b101, 32'h206, 32'h0, 32'h80017FFF, 0, 0, 4'h0, 32'h0, 32'h204, 32'h00008001, 1'b0, 3);
        vecs[9]  = mk(1'b0, 1'b1, 3'b010, 32'h102, 32'h11111111, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        vecs[10] = mk(1'b1, 1'b0, 3'b000, 32'h003, 32'h0, 32'h7F000000, 0, 0, 4'h0, 32'h0, 32'h000, 32'h0000007F, 1'b0, 3);
        vecs[11] = mk(1'b1, 1'b0, 3'b011, 32'h208, 32'h0, 32'h11223344, 0, 0, 4'h0, 32'h0, 32'h208, 32'h11223344, 1'b0, 3);
        vecs[12] = mk(1'b1, 1'b0, 3'b011, 32'h209, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        vecs[13] = mk(1'b0, 1'b1, 3'b000, 32'h101, 32'hFFFFFF5A, 32'h0, 0, 0, 4'h2, 32'h5A5A5A5A, 32'h100, 32'h0, 1'b0, 2);
        vecs[14] = mk(1'b0, 1'b1, 3'b100, 32'h104, 32'h01020304, 32'h0, 0, 0, 4'hF, 32'h01020304, 32'h104, 32'h0, 1'b0, 2);
        vecs[15] = mk(1'b1, 1'b0, 3'b101, 32'h200, 32'h0, 32'h12F03456, 1, 1, 4'h0, 32'h0, 32'h200, 32'h00003456, 1'b0, 5);

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset bus_valid", {31'd0, bus.bus_valid}, 32'd0);
        chk("reset access_done", {31'd0, access_done}, 32'd0);
        chk("reset fault", {31'd0, misaligned_fault}, 32'd0);
        chk("reset load_data", load_data, 32'd0);
        chk("reset busy", {31'd0, memory_busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Handshake inputs in IDLE with no request must be ignored.
        bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h55555555;
        repeat (2) begin
            @(negedge clk);
            chk("idle bus_valid", {31'd0, bus.bus_valid}, 32'd0);
            chk("idle access_done", {31'd0, access_done}, 32'd0);
        end
        bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while waiting for a load response; the late response is dropped.
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
        #1 chk("rst_seq busy c0", {31'd0, memory_busy}, 32'd1);
        @(negedge clk);
        #1 chk("rst_seq bus_valid c1", {31'd0, bus.bus_valid}, 32'd1);
        bus.bus_ready = 1'b1;
        @(negedge clk);
        bus.bus_ready = 1'b0;
        #1 chk("rst_seq in wait", {31'd0, bus.bus_valid}, 32'd0);
        rst_n = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.bus_rdata = 32'hAAAA5555; bus.bus_rvalid = 1'b1;
        #1;
        chk("rst_seq bus_valid", {31'd0, bus.bus_valid}, 32'd0);
        chk("rst_seq load_data", load_data, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.bus_rvalid = 1'b0;
            #1;
            chk("rst_seq no_done", {31'd0, access_done}, 32'd0);
            chk("rst_seq load_hold", load_data, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
